sr_flag_sequencer: RTL and testbench
====================================

// Module: sr_flag_sequencer
// PURPOSE
// - Owns a bank of NFLAGS cross-coupled NOR set/reset latches used as status flags.
// - Arbitrates set/clear requests from NREQ requesters (round-robin) and drives one latch at a time.
// - Each operation is a clean, width-controlled s or r pulse followed by a recovery gap.
// - Guarantees s and r are never both high on any latch.
// PARAMETERS
// - NREQ     4  number of requesters (>=2)
// - NFLAGS   8  number of latches in the bank (>=1)
// - PULSE_W  2  cycles s/r held high per operation (>=1)
// - IW       $clog2(NFLAGS) (min 1)  flag index width (localparam)
// PORTS
// - clk      in   1          rising-edge clock
// - rst_n    in   1          asynchronous reset, active-low
// - req      in   NREQ       request[i]; held high until gnt[i]
// - op       in   NREQ       1 = set, 0 = clear (per requester; sampled at grant)
// - idx      in   NREQ*IW    flag index, requester i in idx[i*IW +: IW]
// - gnt      out  NREQ       one-hot, one-cycle grant pulse
// - s_out    out  NFLAGS     latch set drives
// - r_out    out  NFLAGS     latch reset drives
// - q_in     in   NFLAGS     latch q readback
// - busy     out  1          high whenever state != IDLE
// - done     out  1          one-cycle pulse at end of each operation
// - err      out  1          sticky readback mismatch (see CONFIGURATION)
// - err_clr  in   1          synchronous clear of err
// BEHAVIOUR
// - Reset (async, immediate): state=IDLE; s_out=r_out=0; gnt=0; busy=done=err=0; rr_ptr=0.
// - Reset mid-operation: pulse aborted at once; latch keeps whatever state it reached.
// - FSM states: IDLE, DRIVE, RECOVER, CHECK.
// - IDLE: if |req, winner = first requester at/after rr_ptr with req high (wrapping NREQ-1 -> 0).
//   - On the edge, latch winner's op and idx, go to DRIVE, rr_ptr <= winner+1 (mod NREQ).
// - DRIVE: lasts PULSE_W cycles; gnt[winner]=1 in its first cycle only.
//   - s_out[idx]=1 if op=1, else r_out[idx]=1; all other bits 0.
// - RECOVER: exactly 1 cycle with s_out=r_out=0. Next state is CHECK if SR_VERIFY_EN, else IDLE with done=1.
// - CHECK (1 cycle): compare q_in[idx] against op; mismatch sets err; done=1; then IDLE.
// - Latency: req in IDLE at edge t gives gnt and s/r high in cycle t+1.
//   - done comes PULSE_W+1 cycles after gnt (PULSE_W+2 with verify).
//   - No IDLE gap is skipped: the next grant comes no earlier than the cycle after done.
// - At most one bit of s_out|r_out is high in any cycle; s_out&r_out == 0 always.
// - idx >= NFLAGS: the request is granted and sequenced, but no s/r bit is driven.
//   - With SR_VERIFY_EN, such a request sets err.
// - Repeat op on a flag already in that state: the full pulse still occurs (no short-circuit).
// - req dropped before gnt: protocol violation; behaviour unspecified except s&r exclusivity.
// - err_clr and a new mismatch in the same cycle: the mismatch wins (err=1).
// CONFIGURATION
// - Macro SR_VERIFY_EN.
// - Defined: CHECK state present; readback compare; err sticky until err_clr.
// - Undefined: CHECK omitted (RECOVER -> IDLE); err tied 0; q_in and err_clr unused.
// TESTING
// - Single set: req[0]=1, op[0]=1, idx0=3 -> gnt[0] cycle t+1, s_out=8'h08 for 2 cycles, 1 gap, done; q_in[3]=1.
// - RR fairness: req=4'b1111 held, each re-raised after its gnt -> grant order 0,1,2,3,0; no starvation.
// - Exclusivity: random ops over 2000 cycles -> assertion (s_out&r_out)==0 and $onehot0(s_out|r_out) never fails.
// - Verify error (SR_VERIFY_EN): clear flag 5 with q_in[5] forced 1 -> err=1 after CHECK; err_clr -> err=0.
// - Reset mid-pulse: rst_n low during DRIVE -> s_out/r_out/busy go 0 without a clock edge; first grant after release goes to req[0].
// - PULSE_W=1, NFLAGS=5, idx=7 -> gnt, no s/r bit, done 2 cycles later; err=1 only with SR_VERIFY_EN.

Source files
------------

// File: rtl/sr_flag_sequencer.sv
// Round-robin sequencer driving one SR latch at a time with a PULSE_W-cycle s/r pulse, then a 1-cycle recovery gap.
// Grant and pulse start the cycle after req is seen in IDLE; requesters hold req until gnt. Readback check: SR_VERIFY_EN.
module sr_flag_sequencer #(
    parameter  int NREQ    = 4,
    parameter  int NFLAGS  = 8,
    parameter  int PULSE_W = 2,
    localparam int IW      = (NFLAGS > 1) ? $clog2(NFLAGS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      op,
    input  logic [NREQ*IW-1:0]   idx,
    output logic [NREQ-1:0]      gnt,
    output logic [NFLAGS-1:0]    s_out,
    output logic [NFLAGS-1:0]    r_out,
    input  logic [NFLAGS-1:0]    q_in,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    input  logic                 err_clr
);
    localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, RECOVER, CHECK} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_cnt;
    logic [RW-1:0]     r_win;
    logic [RW-1:0]     r_rr_ptr;
    logic              r_op;
    logic [IW-1:0]     r_idx;
    logic              r_done;
    logic              w_done_nxt;
    logic              w_found;
    logic [RW-1:0]     w_win;
    logic [RW-1:0]     w_nxt_ptr;
    logic              w_req_op;
    logic [IW-1:0]     w_req_idx;
    logic [NFLAGS-1:0] w_sel;

    // Search starts at the round-robin pointer and wraps.
    always_comb begin
        int          j;
        logic [RW-1:0] cand;
        j       = 0;
        cand    = '0;
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            j    = (int'(r_rr_ptr) + k) % NREQ;
            cand = RW'(j);
            if (!w_found && req[cand]) begin
                w_found = 1'b1;
                w_win   = cand;
            end
        end
    end

    always_comb begin
        w_req_op  = 1'b0;
        w_req_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == RW'(i)) begin
                w_req_op  = op[i];
                w_req_idx = idx[i*IW +: IW];
            end
        end
    end

    assign w_nxt_ptr = (w_win == RW'(NREQ - 1)) ? '0 : w_win + RW'(1);
    // Out-of-range indices shift the one-hot off the top, so nothing is driven.
    assign w_sel     = NFLAGS'(1) << r_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_win    <= '0;
            r_rr_ptr <= '0;
            r_op     <= 1'b0;
            r_idx    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_done_nxt;
            r_cnt   <= (r_state == DRIVE) ? r_cnt + CW'(1) : '0;
            if (r_state == IDLE && w_found) begin
                r_win    <= w_win;
                r_op     <= w_req_op;
                r_idx    <= w_req_idx;
                r_rr_ptr <= w_nxt_ptr;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_done_nxt = 1'b0;
        gnt        = '0;
        s_out      = '0;
        r_out      = '0;
        case (r_state)
            IDLE: begin
                if (w_found) w_next = DRIVE;
            end
            DRIVE: begin
                if (r_cnt == '0) gnt = NREQ'(1) << r_win;
                if (r_op) s_out = w_sel;
                else      r_out = w_sel;
                if (r_cnt == CW'(PULSE_W - 1)) w_next = RECOVER;
            end
            RECOVER: begin
`ifdef SR_VERIFY_EN
                w_next     = CHECK;
`else
                w_next     = IDLE;
                w_done_nxt = 1'b1;
`endif
            end
`ifdef SR_VERIFY_EN
            CHECK: begin
                w_next     = IDLE;
                w_done_nxt = 1'b1;
            end
`endif
            default: w_next = IDLE;
        endcase
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;

`ifdef SR_VERIFY_EN
    logic r_err;
    logic w_mismatch;

    // An unaddressable flag can never read back, so it always counts as a mismatch.
    assign w_mismatch = (w_sel == '0) || ((|(q_in & w_sel)) != r_op);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              r_err <= 1'b0;
        else if (r_state == CHECK && w_mismatch) r_err <= 1'b1;
        else if (err_clr)                        r_err <= 1'b0;
    end

    assign err = r_err;
`else
    logic w_unused;
    assign w_unused = &{1'b0, q_in, err_clr};
    assign err      = 1'b0;
`endif
endmodule

// File: tb/tb_sr_flag_sequencer.sv
// Directed bench for sr_flag_sequencer: default instance plus a PULSE_W=1, NFLAGS=5 instance.
module tb_sr_flag_sequencer;
`ifdef SR_VERIFY_EN
    localparam int VER = 1;
`else
    localparam int VER = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [3:0]  req_a = '0, op_a = '0, gnt_a;
    logic [2:0]  idx_arr_a [4];
    logic [11:0] idx_a;
    logic [7:0]  s_a, r_a, q_a;
    logic [7:0]  q_lat = '0, q_force = '0;
    logic        busy_a, done_a, err_a, err_clr_a = 1'b0;

    logic [3:0]  req_b = '0, op_b = '0, gnt_b;
    logic [2:0]  idx_arr_b [4];
    logic [11:0] idx_b;
    logic [4:0]  s_b, r_b;
    logic [4:0]  q_b = '0;
    logic        busy_b, done_b, err_b, err_clr_b = 1'b0;

    int n_chk = 0, n_pass = 0;
    int viol = 0, n_gnt = 0, n_done = 0;
    logic rnd_en = 1'b0;

    always #5 clk = ~clk;

    assign idx_a = {idx_arr_a[3], idx_arr_a[2], idx_arr_a[1], idx_arr_a[0]};
    assign idx_b = {idx_arr_b[3], idx_arr_b[2], idx_arr_b[1], idx_arr_b[0]};
    assign q_a   = q_lat | q_force;

    sr_flag_sequencer dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .op(op_a), .idx(idx_a), .gnt(gnt_a),
        .s_out(s_a), .r_out(r_a), .q_in(q_a), .busy(busy_a), .done(done_a),
        .err(err_a), .err_clr(err_clr_a)
    );

    sr_flag_sequencer #(.NREQ(4), .NFLAGS(5), .PULSE_W(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .op(op_b), .idx(idx_b), .gnt(gnt_b),
        .s_out(s_b), .r_out(r_b), .q_in(q_b), .busy(busy_b), .done(done_b),
        .err(err_b), .err_clr(err_clr_b)
    );

    // Behavioural NOR latch bank for instance A.
    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (s_a[3'(i)])      q_lat[3'(i)] <= 1'b1;
            else if (r_a[3'(i)]) q_lat[3'(i)] <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if ((s_a & r_a) != 8'h0 || !$onehot0(s_a | r_a) || !$onehot0(gnt_a)) viol++;
            if ((s_b & r_b) != 5'h0 || !$onehot0(s_b | r_b) || !$onehot0(gnt_b)) viol++;
            if (rnd_en && gnt_a != 4'h0) n_gnt++;
            if (rnd_en && done_a)        n_done++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    // One full operation on instance A (PULSE_W=2), requester r, checked cycle by cycle.
    task automatic do_op(input int r, input logic o, input int ix,
                         input logic [7:0] es, input logic [7:0] er, input logic exp_err);
        int n;
        req_a[2'(r)]     = 1'b1;
        op_a[2'(r)]      = o;
        idx_arr_a[2'(r)] = 3'(ix);
        n = 0;
        do begin @(negedge clk); n++; end while (gnt_a == 4'h0 && n < 30);
        check("op_gnt", 32'(gnt_a), 32'(1) << r);
        req_a[2'(r)] = 1'b0;
        check("op_s1", 32'(s_a), 32'(es));
        check("op_r1", 32'(r_a), 32'(er));
        @(negedge clk);
        check("op_gnt_pulse", 32'(gnt_a), 32'h0);
        check("op_s2", 32'(s_a), 32'(es));
        check("op_r2", 32'(r_a), 32'(er));
        @(negedge clk);
        check("op_gap", 32'(s_a | r_a), 32'h0);
        check("op_gap_busy", 32'(busy_a), 32'h1);
        check("op_gap_done", 32'(done_a), 32'h0);
`ifdef SR_VERIFY_EN
        @(negedge clk);
        check("op_chk_busy", 32'(busy_a), 32'h1);
        check("op_chk_done", 32'(done_a), 32'h0);
`endif
        @(negedge clk);
        check("op_done", 32'(done_a), 32'h1);
        check("op_idle", 32'(busy_a), 32'h0);
        check("op_err", 32'(err_a), 32'(exp_err));
    endtask

    initial begin
        int n;
        int ord [5] = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 4; i++) begin
            idx_arr_a[i] = '0;
            idx_arr_b[i] = '0;
        end

        #3;
        check("rst_gnt", 32'(gnt_a), 32'h0);
        check("rst_sr", 32'({s_a, r_a}), 32'h0);
        check("rst_busy_done_err", 32'({busy_a, done_a, err_a}), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(0, 1'b1, 3, 8'h08, 8'h00, 1'b0);
        check("q3_set", 32'(q_lat[3]), 32'h1);
        do_op(1, 1'b0, 5, 8'h00, 8'h20, 1'b0);

        q_force = 8'h20;
        do_op(2, 1'b0, 5, 8'h00, 8'h20, 1'(VER));
        q_force = 8'h00;
        err_clr_a = 1'b1;
        @(negedge clk);
        err_clr_a = 1'b0;
        check("err_clr", 32'(err_a), 32'h0);

        do_op(3, 1'b1, 3, 8'h08, 8'h00, 1'b0);

        for (int i = 0; i < 4; i++) begin
            op_a[2'(i)]      = 1'b1;
            idx_arr_a[2'(i)] = 3'(i);
        end
        req_a = 4'hF;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (gnt_a == 4'h0 && n < 30);
            check("rr_gnt", 32'(gnt_a), 32'(1) << ord[k]);
            if (k > 0) check("rr_spacing", 32'(n), 32'(4 + VER));
        end
        req_a = 4'h0;
        repeat (8) @(negedge clk);

        req_a[2] = 1'b1; op_a[2] = 1'b1; idx_arr_a[2] = 3'd6;
        n = 0;
        do begin @(negedge clk); n++; end while (gnt_a == 4'h0 && n < 30);
        check("mid_gnt", 32'(gnt_a), 32'h4);
        check("mid_s", 32'(s_a), 32'h40);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_sr", 32'({s_a, r_a}), 32'h0);
        check("mid_rst_busy", 32'(busy_a), 32'h0);
        check("mid_rst_gnt", 32'(gnt_a), 32'h0);
        req_a = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        req_a = 4'b1011;
        @(negedge clk);
        check("post_rst_gnt", 32'(gnt_a), 32'h1);
        req_a = 4'h0;
        repeat (8) @(negedge clk);

        rnd_en = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (req_a[2'(i)] && gnt_a[2'(i)]) req_a[2'(i)] = 1'b0;
                else if (!req_a[2'(i)] && $urandom_range(0, 3) == 0) begin
                    req_a[2'(i)]     = 1'b1;
                    op_a[2'(i)]      = 1'($urandom_range(0, 1));
                    idx_arr_a[2'(i)] = 3'($urandom_range(0, 7));
                end
            end
        end
        n = 0;
        while (req_a != 4'h0 && n < 300) begin
            @(negedge clk);
            n++;
            for (int i = 0; i < 4; i++)
                if (gnt_a[2'(i)]) req_a[2'(i)] = 1'b0;
        end
        check("rnd_drain", 32'(req_a), 32'h0);
        repeat (8) @(negedge clk);
        rnd_en = 1'b0;
        check("rnd_gnt_eq_done", 32'(n_done), 32'(n_gnt));
        check("rnd_activity", 32'(n_gnt > 100), 32'h1);

        req_b[0] = 1'b1; op_b[0] = 1'b0; idx_arr_b[0] = 3'd4;
        n = 0;
        do begin @(negedge clk); n++; end while (gnt_b == 4'h0 && n < 30);
        check("b_gnt0", 32'(gnt_b), 32'h1);
        check("b_r4", 32'({s_b, r_b}), 32'h10);
        req_b[0] = 1'b0;
        @(negedge clk);
        check("b_gap", 32'({s_b, r_b, done_b}), 32'h0);
`ifdef SR_VERIFY_EN
        @(negedge clk);
        check("b_chk_done", 32'(done_b), 32'h0);
`endif
        @(negedge clk);
        check("b_done", 32'(done_b), 32'h1);
        check("b_err_ok", 32'(err_b), 32'h0);

        req_b[1] = 1'b1; op_b[1] = 1'b1; idx_arr_b[1] = 3'd7;
        n = 0;
        do begin @(negedge clk); n++; end while (gnt_b == 4'h0 && n < 30);
        check("b_gnt1", 32'(gnt_b), 32'h2);
        check("b_oob_sr", 32'({s_b, r_b}), 32'h0);
        check("b_oob_busy", 32'(busy_b), 32'h1);
        req_b[1] = 1'b0;
        @(negedge clk);
        check("b_oob_gap", 32'(done_b), 32'h0);
`ifdef SR_VERIFY_EN
        @(negedge clk);
        check("b_oob_chk", 32'(done_b), 32'h0);
`endif
        @(negedge clk);
        check("b_oob_done", 32'(done_b), 32'h1);
        check("b_oob_err", 32'(err_b), 32'(VER));

        check("exclusivity", 32'(viol), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_chk);
        $fatal(1);
    end
endmodule
